// File: rtl/axis_tdest_demux_n.sv
`default_nettype none
// ============================================================================
// Module   : axis_tdest_demux_n
// Purpose  : Packet-aware AXI4-Stream demultiplexer. Routes each input frame
//            to one of M_COUNT output channels chosen by s_axis_tdest on the
//            frame's first beat. The route is held for the whole frame, the
//            output stage is registered, and frames with an out-of-range
//            destination are either dropped and counted or sent to the last
//            channel.
// Ports    : clk, rst             - clock, asynchronous active-high reset
//            s_axis_*             - single slave stream (tdata/tkeep/tvalid/
//                                   tready/tlast/tdest)
//            m_axis_*             - M_COUNT master streams; tdata/tkeep are
//                                   broadcast, tvalid/tlast per channel
//            status_drop          - one-cycle pulse per dropped frame
//            status_drop_count    - saturating count of dropped frames
// Revision : 1.0 - initial release
// ============================================================================
module axis_tdest_demux_n #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int M_COUNT         = 3,
    parameter int AXIS_DEST_WIDTH = 2,
    parameter int DROP_INVALID    = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]           s_axis_tkeep,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic                                 s_axis_tlast,
    input  logic [AXIS_DEST_WIDTH-1:0]           s_axis_tdest,
    output logic [M_COUNT*AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [M_COUNT*AXIS_KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic [M_COUNT-1:0]                   m_axis_tvalid,
    input  logic [M_COUNT-1:0]                   m_axis_tready,
    output logic [M_COUNT-1:0]                   m_axis_tlast,
    output logic                                 status_drop,
    output logic [15:0]                          status_drop_count
);

    localparam int c_SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
    localparam logic [AXIS_DEST_WIDTH:0] c_M_COUNT_EXT = (AXIS_DEST_WIDTH + 1)'(M_COUNT);
    localparam logic [c_SEL_W-1:0]       c_LAST_CH     = c_SEL_W'(M_COUNT - 1);
    localparam logic                     c_DROP_EN     = (DROP_INVALID != 0);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_FWD  = 2'd1;
    localparam logic [1:0] c_ST_DROP = 2'd2;

    logic [1:0]                 r_state_q,     w_state_d;
    logic [c_SEL_W-1:0]         r_sel_q,       w_sel_d;
    logic [AXIS_DATA_WIDTH-1:0] r_out_data_q,  w_out_data_d;
    logic [AXIS_KEEP_WIDTH-1:0] r_out_keep_q,  w_out_keep_d;
    logic                       r_out_last_q,  w_out_last_d;
    logic                       r_out_valid_q, w_out_valid_d;
    logic [c_SEL_W-1:0]         r_out_sel_q,   w_out_sel_d;
    logic                       r_drop_q,      w_drop_d;
    logic [15:0]                r_drop_cnt_q,  w_drop_cnt_d;

    logic               w_dest_ok;
    logic               w_first;
    logic               w_drop_beat;
    logic               w_out_ready;
    logic               w_pass_ready;
    logic               w_s_ready;
    logic               w_accept;
    logic               w_load;
    logic [c_SEL_W-1:0] w_route;

    always_comb begin
        w_dest_ok    = ({1'b0, s_axis_tdest} < c_M_COUNT_EXT);
        w_first      = (r_state_q == c_ST_IDLE);
        // A beat is discarded either mid-way through a dropped frame or when
        // it opens a frame whose destination does not exist.
        w_drop_beat  = (r_state_q == c_ST_DROP) || (w_first && !w_dest_ok && c_DROP_EN);
        w_out_ready  = m_axis_tready[r_out_sel_q];
        w_pass_ready = !r_out_valid_q || w_out_ready;
        // Discarded mid-frame beats never touch the output register, so they
        // can be swallowed regardless of downstream back-pressure.
        w_s_ready    = !rst && ((r_state_q == c_ST_DROP) || w_pass_ready);
        w_accept     = s_axis_tvalid && w_s_ready;
        w_load       = w_accept && !w_drop_beat;
        if (!w_first) begin
            w_route = r_sel_q;
        end else if (w_dest_ok) begin
            w_route = s_axis_tdest[c_SEL_W-1:0];
        end else begin
            w_route = c_LAST_CH;
        end

        w_state_d = r_state_q;
        w_sel_d   = r_sel_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_sel_d = w_route;
                    if (!s_axis_tlast) begin
                        w_state_d = w_drop_beat ? c_ST_DROP : c_ST_FWD;
                    end
                end
            end
            c_ST_FWD, c_ST_DROP: begin
                if (w_accept && s_axis_tlast) begin
                    w_state_d = c_ST_IDLE;
                end
            end
            default: w_state_d = c_ST_IDLE;
        endcase

        w_out_data_d  = r_out_data_q;
        w_out_keep_d  = r_out_keep_q;
        w_out_last_d  = r_out_last_q;
        w_out_valid_d = r_out_valid_q;
        w_out_sel_d   = r_out_sel_q;
        if (w_load) begin
            w_out_data_d  = s_axis_tdata;
            w_out_keep_d  = s_axis_tkeep;
            w_out_last_d  = s_axis_tlast;
            w_out_valid_d = 1'b1;
            w_out_sel_d   = w_route;
        end else if (r_out_valid_q && w_out_ready) begin
            w_out_valid_d = 1'b0;
        end

        w_drop_d     = w_accept && s_axis_tlast && w_drop_beat;
        w_drop_cnt_d = r_drop_cnt_q;
        if (w_drop_d && (r_drop_cnt_q != 16'hFFFF)) begin
            w_drop_cnt_d = r_drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= c_ST_IDLE;
            r_sel_q       <= '0;
            r_out_data_q  <= '0;
            r_out_keep_q  <= '0;
            r_out_last_q  <= 1'b0;
            r_out_valid_q <= 1'b0;
            r_out_sel_q   <= '0;
            r_drop_q      <= 1'b0;
            r_drop_cnt_q  <= 16'd0;
        end else begin
            r_state_q     <= w_state_d;
            r_sel_q       <= w_sel_d;
            r_out_data_q  <= w_out_data_d;
            r_out_keep_q  <= w_out_keep_d;
            r_out_last_q  <= w_out_last_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_sel_q   <= w_out_sel_d;
            r_drop_q      <= w_drop_d;
            r_drop_cnt_q  <= w_drop_cnt_d;
        end
    end

    assign s_axis_tready     = w_s_ready;
    assign status_drop       = r_drop_q;
    assign status_drop_count = r_drop_cnt_q;

    // Data and keep are broadcast; only the selected channel sees valid/last.
    for (genvar i = 0; i < M_COUNT; i++) begin : g_ch
        logic w_hit;
        assign w_hit = r_out_valid_q && (r_out_sel_q == c_SEL_W'(i));
        assign m_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = r_out_data_q;
        assign m_axis_tkeep[i*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH] = r_out_keep_q;
        assign m_axis_tvalid[i] = w_hit;
        assign m_axis_tlast[i]  = w_hit && r_out_last_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_tdest_demux_n.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axis_tdest_demux_n
// Purpose  : Self-checking bench for axis_tdest_demux_n. Two instances share
//            the input stream: dut_a drops invalid destinations, dut_b sends
//            them to the last channel. A reference model pushes expected
//            beats into per-instance queues on every accepted input beat; a
//            monitor pops and compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_tdest_demux_n;

    localparam int c_W  = 64;
    localparam int c_K  = 8;
    localparam int c_M  = 3;
    localparam int c_DW = 2;

    typedef struct {
        logic [1:0]     ch;
        logic [c_W-1:0] data;
        logic [c_K-1:0] keep;
        logic           last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [c_W-1:0]   s_tdata = '0;
    logic [c_K-1:0]   s_tkeep = '0;
    logic             s_tvalid = 1'b0;
    logic             s_tlast = 1'b0;
    logic [c_DW-1:0]  s_tdest = '0;
    logic [c_M-1:0]   m_tready = '1;

    logic             a_ready, b_ready;
    logic [c_M*c_W-1:0] a_tdata, b_tdata;
    logic [c_M*c_K-1:0] a_tkeep, b_tkeep;
    logic [c_M-1:0]   a_tvalid, b_tvalid, a_tlast, b_tlast;
    logic             a_drop, b_drop;
    logic [15:0]      a_cnt, b_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    beat_t q_a[$];
    beat_t q_b[$];
    logic       a_in_frame = 1'b0, a_dropping = 1'b0, b_in_frame = 1'b0;
    logic [1:0] a_ch = '0, b_ch = '0;
    logic [15:0] exp_cnt_a = '0;
    int exp_pulses_a = 0;
    int obs_pulses_a = 0;

    logic count_en = 1'b0;
    int   vcount = 0;
    int   first_v = -1;
    int   last_v = -1;
    int   acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axis_tdest_demux_n #(.AXIS_DATA_WIDTH(c_W), .AXIS_KEEP_WIDTH(c_K), .M_COUNT(c_M),
                         .AXIS_DEST_WIDTH(c_DW), .DROP_INVALID(1)) dut_a (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(a_ready), .s_axis_tlast(s_tlast), .s_axis_tdest(s_tdest),
        .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep), .m_axis_tvalid(a_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(a_tlast),
        .status_drop(a_drop), .status_drop_count(a_cnt));

    axis_tdest_demux_n #(.AXIS_DATA_WIDTH(c_W), .AXIS_KEEP_WIDTH(c_K), .M_COUNT(c_M),
                         .AXIS_DEST_WIDTH(c_DW), .DROP_INVALID(0)) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(b_ready), .s_axis_tlast(s_tlast), .s_axis_tdest(s_tdest),
        .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tvalid(b_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(b_tlast),
        .status_drop(b_drop), .status_drop_count(b_cnt));

    // Reference model: called once per accepted input beat.
    task automatic model_accept(input logic [c_W-1:0] d, input logic [c_K-1:0] k,
                                input logic l, input logic [1:0] dest);
        beat_t e;
        if (!a_in_frame) begin
            if (dest < 2'd3) begin
                a_dropping = 1'b0;
                a_ch = dest;
            end else begin
                a_dropping = 1'b1;
            end
        end
        if (!a_dropping) begin
            e.ch = a_ch; e.data = d; e.keep = k; e.last = l;
            q_a.push_back(e);
        end
        if (l) begin
            a_in_frame = 1'b0;
            if (a_dropping) begin
                exp_pulses_a++;
                if (exp_cnt_a != 16'hFFFF) exp_cnt_a = exp_cnt_a + 16'd1;
            end
        end else begin
            a_in_frame = 1'b1;
        end
        if (!b_in_frame) b_ch = (dest < 2'd3) ? dest : 2'd2;
        e.ch = b_ch; e.data = d; e.keep = k; e.last = l;
        q_b.push_back(e);
        b_in_frame = !l;
    endtask

    task automatic model_reset();
        q_a.delete();
        q_b.delete();
        a_in_frame = 1'b0;
        a_dropping = 1'b0;
        b_in_frame = 1'b0;
        exp_cnt_a  = '0;
    endtask

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (rst === 1'b0) begin
            checks++;
            if ($countones(a_tvalid) > 1 || $countones(b_tvalid) > 1) begin
                errors++;
                $display("FAIL onehot_valid a=%b b=%b required at most one bit", a_tvalid, b_tvalid);
            end
            if (a_drop === 1'b1) obs_pulses_a++;
            if (count_en && a_tvalid != '0) begin
                vcount++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            for (int ch = 0; ch < c_M; ch++) begin
                if (a_tvalid[ch] && m_tready[ch]) begin
                    checks++;
                    if (q_a.size() == 0) begin
                        errors++;
                        $display("FAIL a_unexpected ch=%0d data=%h required no beat", ch, a_tdata[ch*c_W +: c_W]);
                    end else begin
                        e = q_a.pop_front();
                        if ({2'(ch), a_tdata[ch*c_W +: c_W], a_tkeep[ch*c_K +: c_K], a_tlast[ch]} !==
                            {e.ch, e.data, e.keep, e.last}) begin
                            errors++;
                            $display("FAIL a_beat got ch=%0d data=%h keep=%h last=%b required ch=%0d data=%h keep=%h last=%b",
                                     ch, a_tdata[ch*c_W +: c_W], a_tkeep[ch*c_K +: c_K], a_tlast[ch],
                                     e.ch, e.data, e.keep, e.last);
                        end
                    end
                end
                if (b_tvalid[ch] && m_tready[ch]) begin
                    checks++;
                    if (q_b.size() == 0) begin
                        errors++;
                        $display("FAIL b_unexpected ch=%0d data=%h required no beat", ch, b_tdata[ch*c_W +: c_W]);
                    end else begin
                        e = q_b.pop_front();
                        if ({2'(ch), b_tdata[ch*c_W +: c_W], b_tkeep[ch*c_K +: c_K], b_tlast[ch]} !==
                            {e.ch, e.data, e.keep, e.last}) begin
                            errors++;
                            $display("FAIL b_beat got ch=%0d data=%h keep=%h last=%b required ch=%0d data=%h keep=%h last=%b",
                                     ch, b_tdata[ch*c_W +: c_W], b_tkeep[ch*c_K +: c_K], b_tlast[ch],
                                     e.ch, e.data, e.keep, e.last);
                        end
                    end
                end
            end
        end
    end

    // Drive one beat (entered just after a rising edge) and wait for acceptance.
    task automatic send_beat(input logic [c_W-1:0] d, input logic l,
                             input logic [1:0] dest, output int waits);
        logic ok;
        logic [c_K-1:0] k;
        k = d[7:0] ^ 8'h5A;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tdest = dest; s_tvalid = 1'b1;
        waits = 0;
        ok = 1'b0;
        while (!ok && waits <= 50) begin
            @(negedge clk);
            checks++;
            if (a_ready !== b_ready) begin
                errors++;
                $display("FAIL tready_match a=%b b=%b required equal", a_ready, b_ready);
            end
            if (a_ready === 1'b1 && b_ready === 1'b1) begin
                model_accept(d, k, l, dest);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ok) acc_cyc = cyc;
            else    waits++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout data=%h waited=%0d cycles required acceptance", d, waits);
        end
    endtask

    task automatic send_frame(input logic [1:0] dest, input int n, input logic [c_W-1:0] base);
        int w;
        for (int i = 0; i < n; i++) send_beat(base + c_W'(i), (i == n - 1), dest, w);
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a_tvalid, a_tlast, a_tdata, a_tkeep, a_drop, a_cnt, a_ready} !== '0) begin
            errors++;
            $display("FAIL reset_a valid=%b last=%b data=%h keep=%h drop=%b cnt=%0d ready=%b required all zero",
                     a_tvalid, a_tlast, a_tdata, a_tkeep, a_drop, a_cnt, a_ready);
        end
        checks++;
        if ({b_tvalid, b_tlast, b_tdata, b_tkeep, b_drop, b_cnt, b_ready} !== '0) begin
            errors++;
            $display("FAIL reset_b valid=%b last=%b ready=%b required all zero", b_tvalid, b_tlast, b_ready);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int first_acc;
        vcount = 0; first_v = -1; last_v = -1; count_en = 1'b1;
        send_beat(64'h1000, 1'b0, 2'd0, first_acc);
        first_acc = acc_cyc;
        send_frame(2'd0, 3, 64'h1001);
        send_frame(2'd1, 4, 64'h2000);
        send_frame(2'd2, 4, 64'h3000);
        idle(4);
        count_en = 1'b0;
        checks++;
        if (vcount != 12) begin
            errors++;
            $display("FAIL basic_valid_cycles got %0d required 12", vcount);
        end
        checks++;
        if (last_v - first_v != 11) begin
            errors++;
            $display("FAIL basic_contiguous span=%0d required 11", last_v - first_v);
        end
        checks++;
        if (first_v != first_acc) begin
            errors++;
            $display("FAIL basic_latency first valid cycle=%0d required %0d", first_v, first_acc);
        end
        checks++;
        if (a_cnt !== 16'd0) begin
            errors++;
            $display("FAIL basic_drop_count got %0d required 0", a_cnt);
        end
    endtask

    task automatic test_tdest_change();
        int w;
        send_beat(64'h4000, 1'b0, 2'd0, w);
        send_beat(64'h4001, 1'b0, 2'd2, w);
        send_beat(64'h4002, 1'b0, 2'd1, w);
        send_beat(64'h4003, 1'b1, 2'd2, w);
        idle(3);
    endtask

    task automatic test_drop();
        int w;
        int maxw;
        maxw = 0;
        for (int i = 0; i < 5; i++) begin
            send_beat(64'h5000 + c_W'(i), (i == 4), 2'd3, w);
            if (w > maxw) maxw = w;
        end
        send_beat(64'h5100, 1'b1, 2'd3, w);
        if (w > maxw) maxw = w;
        idle(4);
        checks++;
        if (maxw != 0) begin
            errors++;
            $display("FAIL drop_ready stall cycles=%0d required 0", maxw);
        end
        checks++;
        if (a_cnt !== exp_cnt_a || exp_cnt_a != 16'd2) begin
            errors++;
            $display("FAIL drop_count got %0d required %0d", a_cnt, exp_cnt_a);
        end
        checks++;
        if (obs_pulses_a != exp_pulses_a) begin
            errors++;
            $display("FAIL drop_pulses got %0d required %0d", obs_pulses_a, exp_pulses_a);
        end
        checks++;
        if (b_cnt !== 16'd0) begin
            errors++;
            $display("FAIL route_last_count got %0d required 0", b_cnt);
        end
    endtask

    task automatic test_backpressure();
        fork
            send_frame(2'd1, 4, 64'h6000);
            begin
                logic [c_W-1:0] snap;
                int t;
                t = 0;
                while (a_tvalid[1] !== 1'b1 && t < 20) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk);
                #1;
                snap = a_tdata[c_W +: c_W];
                m_tready[1] = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checks++;
                    if (a_ready !== 1'b0 || a_tvalid[1] !== 1'b1 || a_tdata[c_W +: c_W] !== snap) begin
                        errors++;
                        $display("FAIL stall_hold ready=%b valid=%b data=%h required ready=0 valid=1 data=%h",
                                 a_ready, a_tvalid[1], a_tdata[c_W +: c_W], snap);
                    end
                    @(posedge clk);
                    #1;
                end
                m_tready[1] = 1'b1;
            end
        join
        idle(4);
    endtask

    task automatic test_reset_midframe();
        int w;
        send_beat(64'h7000, 1'b0, 2'd0, w);
        send_beat(64'h7001, 1'b0, 2'd0, w);
        s_tdata = 64'h7002; s_tlast = 1'b0; s_tvalid = 1'b1;
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (a_tvalid !== '0 || b_tvalid !== '0 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_async a_valid=%b b_valid=%b ready=%b required 0/0/0", a_tvalid, b_tvalid, a_ready);
        end
        s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(2'd1, 4, 64'h7100);
        idle(4);
        checks++;
        if (a_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_drop_count got %0d required 0", a_cnt);
        end
    endtask

    task automatic test_saturation();
        int w;
        for (int i = 0; i < 65540; i++) send_beat(c_W'(i), 1'b1, 2'd3, w);
        idle(4);
        checks++;
        if (a_cnt !== 16'hFFFF || exp_cnt_a != 16'hFFFF) begin
            errors++;
            $display("FAIL drop_saturate got %h required ffff", a_cnt);
        end
        checks++;
        if (obs_pulses_a != exp_pulses_a) begin
            errors++;
            $display("FAIL drop_pulses_sat got %0d required %0d", obs_pulses_a, exp_pulses_a);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_tdest_change();
        test_drop();
        test_backpressure();
        test_reset_midframe();
        test_saturation();
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL leftover_beats a=%0d b=%0d required 0", q_a.size(), q_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_tdest_demux_n.md
# axis_tdest_demux_n

Packet-aware AXI4-Stream demultiplexer that routes each input frame to one of M_COUNT output channels, selected by s_axis_tdest. It is the parametrised successor of the fixed three-way scheduler demux and sits between the scheduler and the per-TX FIFOs. It latches the route on the first beat of each frame, keeps it for the whole frame, and registers the output stage. Frames with an out-of-range destination are optionally dropped and counted.

## Interface
Parameters:
- AXIS_DATA_WIDTH, 64, tdata width in bits
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width
- M_COUNT, 3, number of output channels (2..16)
- AXIS_DEST_WIDTH, 2, tdest width; must satisfy 2^AXIS_DEST_WIDTH >= M_COUNT
- DROP_INVALID, 1, 1 = drop frames with tdest >= M_COUNT; 0 = route them to channel M_COUNT-1

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  reset, asynchronous and active-high
- s_axis_tdata  in  AXIS_DATA_WIDTH  input data
- s_axis_tkeep  in  AXIS_KEEP_WIDTH  input byte enables
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  end of frame
- s_axis_tdest  in  AXIS_DEST_WIDTH  destination; sampled only on a frame's first beat
- m_axis_tdata  out  M_COUNT*AXIS_DATA_WIDTH  per-channel data, channel i at slice [i*W +: W]
- m_axis_tkeep  out  M_COUNT*AXIS_KEEP_WIDTH  per-channel tkeep
- m_axis_tvalid  out  M_COUNT  per-channel valid; at most one bit is set at any time
- m_axis_tready  in  M_COUNT  per-channel ready
- m_axis_tlast  out  M_COUNT  per-channel tlast; gated by that channel's select
- status_drop  out  1  one-cycle pulse when the tlast of a dropped frame is accepted
- status_drop_count  out  16  number of dropped frames; saturates at 0xFFFF

## Operation
- FSM has three states: IDLE (no frame in progress), FWD (forwarding to the latched channel sel), DROP (discarding the current frame).
- First beat of a frame = a beat accepted while in IDLE.
  - If tdest < M_COUNT: sel = tdest.
  - If tdest >= M_COUNT and DROP_INVALID=0: sel = M_COUNT-1.
  - If tdest >= M_COUNT and DROP_INVALID=1: the beat is dropped.
- After the first beat, the next state is FWD or DROP unless that beat has tlast set, in which case the FSM stays in IDLE.
- In FWD or DROP, tdest is ignored. Accepting a beat with tlast returns the FSM to IDLE.
- The output stage is a single register holding data, keep, last, valid and channel (out_sel).
  - tdata and tkeep are broadcast on every channel slice.
  - Only m_axis_tvalid[out_sel] and m_axis_tlast[out_sel] may be 1.
- Ready rule:
  - FWD path and first beats: s_axis_tready = !out_valid || m_axis_tready[out_sel].
  - DROP state: s_axis_tready = 1; the beat is never written to the output register.
  - First beat of a dropped frame: accepted under the normal ready rule and not loaded into the output register.
- The output register loads on (s_axis_tvalid && s_axis_tready && the beat is not dropped). It clears valid when its beat is taken and no new beat is loaded.
- status_drop_count increments on each status_drop pulse until it saturates. A frame with a single invalid beat counts as one drop.
- Output register contents stay stable while m_axis_tvalid=1 and the selected tready=0.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is presented on the m_axis outputs after edge N.
- Throughput is one beat per cycle when the selected channel holds tready=1, including back-to-back frames to different channels. There is no bubble at frame boundaries.
- While rst=1 (asynchronous):
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0
  - status_drop=0, status_drop_count=0
  - FSM in IDLE, sel=0
  - s_axis_tready=0
- s_axis_tready may rise in the first cycle after rst deasserts.
- Reset mid-frame discards the partial frame without counting it. The next accepted beat is treated as a first beat.
- Back-pressure on a channel other than out_sel has no effect.
- Backpressure on out_sel stalls the input, including the first beat of the next frame even if that frame targets another channel. Frames are delivered strictly in order.
- A tdest change mid-frame has no effect.

## Test plan
- Reset, then 3 frames of 4 beats each with tdest=0,1,2 and all tready=1 -> each frame appears only on its channel, 1-cycle latency, 12 consecutive valid cycles, drop count 0.
- Frame with tdest=0 whose beat 2 carries tdest=2 -> all 4 beats go to channel 0.
- DROP_INVALID=1, tdest=3 with M_COUNT=3, frames of 5 beats and 1 beat -> no m_axis_tvalid, s_axis_tready=1 throughout, status_drop pulses twice, count=2. Repeat with DROP_INVALID=0 -> frames appear on channel 2.
- m_axis_tready[1] held low 3 cycles mid-frame on channel 1 -> s_axis_tready low for those 3 cycles, output data stable, no beat lost or duplicated.
- rst pulse while beat 2 of 4 is in flight on channel 0 -> all m_axis_tvalid drop to 0 immediately. The next frame with tdest=1 routes correctly.
- Force 65540 dropped single-beat frames -> status_drop_count holds at 0xFFFF.
